// File: rtl/dstack_unit.sv
// dstack_unit - parametrised data-stack storage for the execute stage.
//
// Holds DEPTH entries (s[0] is the top of stack), applies the per-cycle
// movement/rotate command together with the decoded next_top value, tracks
// the number of valid entries and raises sticky overflow/underflow flags.
//
// Ports
//   clk, reset      clock and synchronous active-high reset
//   halt            freezes all state (entries, count, flags) for the cycle
//   movement        00 hold, 01 push, 10 pop one, 11 pop two
//   rotate          rotate entries 0..rotate_addr (movement ignored when set)
//   rotate_addr     rotate depth and rotate_value read index
//   next_top        new entry 0 for every accepted command
//   clear_flags     clears overflow/underflow (an error the same cycle wins)
//   top/second/third  registered entries 0, 1, 2
//   rotate_value    entry[rotate_addr], 0 when rotate_addr >= DEPTH
//   count           number of valid entries, 0..DEPTH
//   overflow        sticky, push attempted on a full stack
//   underflow       sticky, pop/rotate beyond the valid entries
module dstack_unit #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic [1:0]            movement,
  input  logic                  rotate,
  input  logic [5:0]            rotate_addr,
  input  logic [WORD_WIDTH-1:0] next_top,
  input  logic                  clear_flags,
  output logic [WORD_WIDTH-1:0] top,
  output logic [WORD_WIDTH-1:0] second,
  output logic [WORD_WIDTH-1:0] third,
  output logic [WORD_WIDTH-1:0] rotate_value,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [WORD_WIDTH-1:0] s     [DEPTH];
  logic [WORD_WIDTH-1:0] s_nxt [DEPTH];
  logic [CW-1:0]         count_nxt;
  logic                  ov_err;
  logic                  un_err;
  logic [7:0]            k_ext;
  logic [7:0]            cnt_ext;
  logic                  rot_ok;

  // 8-bit compares cover rotate_addr (6 bits) and count (up to 7 bits).
  assign k_ext   = {2'b00, rotate_addr};
  assign cnt_ext = 8'(count);
  assign rot_ok  = (k_ext < 8'(DEPTH)) && (k_ext < cnt_ext);

  always_comb begin
    s_nxt     = s;
    count_nxt = count;
    ov_err    = 1'b0;
    un_err    = 1'b0;
    if (rotate) begin
      if (rot_ok) begin
        s_nxt[0] = next_top;
        for (int i = 1; i < DEPTH; i++)
          if (8'(i) <= k_ext) s_nxt[i] = s[i-1];
      end else begin
        un_err = 1'b1;
      end
    end else begin
      case (movement)
        2'b00: s_nxt[0] = next_top;
        2'b01: begin
          if (count == CW'(DEPTH)) begin
            ov_err = 1'b1;
          end else begin
            s_nxt[0] = next_top;
            for (int i = 1; i < DEPTH; i++) s_nxt[i] = s[i-1];
            count_nxt = count + 1'b1;
          end
        end
        2'b10: begin
          if (count == '0) begin
            un_err = 1'b1;
          end else begin
            s_nxt[0] = next_top;
            for (int i = 1; i < DEPTH - 1; i++) s_nxt[i] = s[i+1];
            s_nxt[DEPTH-1] = '0;
            count_nxt = count - 1'b1;
          end
        end
        default: begin
          if (count < CW'(2)) begin
            un_err = 1'b1;
          end else begin
            s_nxt[0] = next_top;
            for (int i = 1; i < DEPTH - 2; i++) s_nxt[i] = s[i+2];
            s_nxt[DEPTH-2] = '0;
            s_nxt[DEPTH-1] = '0;
            count_nxt = count - CW'(2);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!halt) begin
      s         <= s_nxt;
      count     <= count_nxt;
      overflow  <= ov_err | (overflow  & ~clear_flags);
      underflow <= un_err | (underflow & ~clear_flags);
    end
  end

  always_comb begin
    rotate_value = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rotate_addr == 6'(i)) rotate_value = s[i];
  end

  assign top    = s[0];
  assign second = s[1];
  assign third  = s[2];

endmodule
